// File: rtl/conv_window_seq_if.sv
// Column-fetch, PE-control and result-report signals shared between the
// window sequencer (master) and the image memory / PE array (slave).
interface conv_window_seq_if #(
  parameter int ADDR_W = 16
);
  logic              col_req;
  logic [ADDR_W-1:0] col_addr;
  logic              col_ack;
  logic              load_en;
  logic              pe_clear;
  logic              pe_trigger;
  logic              calc_done;
  logic              out_valid;
  logic [7:0]        out_row;
  logic [7:0]        out_col;

  modport master (
    output col_req, col_addr, load_en, pe_clear, pe_trigger,
           out_valid, out_row, out_col,
    input  col_ack, calc_done
  );

  modport slave (
    input  col_req, col_addr, load_en, pe_clear, pe_trigger,
           out_valid, out_row, out_col,
    output col_ack, calc_done
  );
endinterface

// File: rtl/conv_window_seq.sv
// Raster-order sequencer for one convolution layer: sliding-window column
// fetch, PE clear/trigger, completion wait and output-coordinate report.
//
// state     | meaning
// IDLE      | waiting for start
// CLEAR     | one-cycle PE accumulator clear
// FETCH     | requesting image columns until the window holds K_W
// CALC      | one-cycle PE trigger
// WAIT_CALC | waiting for the datapath completion pulse
// ADV       | report output, step to next position
// DONE      | one-cycle end-of-layer pulse
module conv_window_seq #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IN_H   = 16,
  parameter int IN_W   = 15,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  conv_window_seq_if.master bus
);

  localparam int OUT_H  = IN_H - K_H + 1;
  localparam int OUT_W  = IN_W - K_W + 1;
  localparam int FC_W   = $clog2(IN_W + 1);
  localparam int FILL_W = $clog2(K_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_CALC,
    S_WAIT_CALC,
    S_ADV,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        row_q, col_q;
  logic [FC_W-1:0]   fc_q;
  logic [FILL_W-1:0] fill_q;

  logic last_fill, last_col, last_row;

  assign last_fill = (fill_q == FILL_W'(K_W - 1));
  assign last_col  = (col_q == 8'(OUT_W - 1));
  assign last_row  = (row_q == 8'(OUT_H - 1));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b1;
    done           = 1'b0;
    bus.col_req    = 1'b0;
    bus.pe_clear   = 1'b0;
    bus.pe_trigger = 1'b0;
    bus.out_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        bus.pe_clear = 1'b1;
        state_d      = S_FETCH;
      end
      S_FETCH: begin
        bus.col_req = 1'b1;
        if (bus.col_ack && last_fill) state_d = S_CALC;
      end
      S_CALC: begin
        bus.pe_trigger = 1'b1;
        state_d        = S_WAIT_CALC;
      end
      S_WAIT_CALC: begin
        if (bus.calc_done) state_d = S_ADV;
      end
      S_ADV: begin
        bus.out_valid = 1'b1;
        state_d       = (last_col && last_row) ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Counters freeze on abort; the next start reinitialises them anyway.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q  <= '0;
      col_q  <= '0;
      fc_q   <= '0;
      fill_q <= '0;
    end else if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_q  <= '0;
            col_q  <= '0;
            fc_q   <= '0;
            fill_q <= '0;
          end
        end
        S_FETCH: begin
          if (bus.col_ack) begin
            fc_q   <= fc_q + FC_W'(1);
            fill_q <= fill_q + FILL_W'(1);
          end
        end
        S_ADV: begin
          if (!last_col) begin
            col_q  <= col_q + 8'd1;
            fill_q <= FILL_W'(K_W - 1);
          end else if (!last_row) begin
            row_q  <= row_q + 8'd1;
            col_q  <= '0;
            fc_q   <= '0;
            fill_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.load_en  = bus.col_req & bus.col_ack;
  assign bus.col_addr = ADDR_W'(32'(row_q) * 32'(IN_W) + 32'(fc_q));
  assign bus.out_row  = row_q;
  assign bus.out_col  = col_q;

endmodule

// File: tb/tb_conv_window_seq.sv
// Bench for conv_window_seq: table of whole-layer passes under different
// memory/datapath timing, plus abort and asynchronous-reset sequences.
module tb_conv_window_seq;
  localparam int K_H    = 3;
  localparam int K_W    = 3;
  localparam int IN_H   = 16;
  localparam int IN_W   = 15;
  localparam int ADDR_W = 16;
  localparam int OUT_H  = IN_H - K_H + 1;
  localparam int OUT_W  = IN_W - K_W + 1;

  logic clk = 1'b0;
  logic rst_ni, start, abort, busy, done;

  conv_window_seq_if #(.ADDR_W(ADDR_W)) bus ();

  conv_window_seq #(
    .K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .abort(abort),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ack_mode;    // 0 zero-wait, 1 ack every 3rd cycle, 2 random wait 0..3
    int calc_max;    // calc_done comes 1..calc_max cycles after pe_trigger
    bit spurious;    // stray calc_done in FETCH, stray col_ack outside FETCH
    bit hold_start;  // keep start high for the whole pass
    int exp_outs;
    int exp_loads;
    int exp_last;
  } vec_t;

  vec_t tbl[6];

  int total = 0, bad = 0;
  int ack_mode, calc_max;
  bit spurious;
  bit ack_pend;
  int ack_cnt, calc_left;
  int ack_wait_sum, calc_extra_sum;
  int outs, loads, dones, last_addr;
  bit clr_seen;
  int clr_cnt, done_at;
  bit prev_req, prev_ack;
  int prev_addr;
  int cyc = 0;
  int abort_idx;
  bit abort_next;
  int exp_r[$], exp_c[$], exp_a[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: unexpected event, value %0d", name, act);
  endtask

  // Reference: raster order; each output fetches the whole window at the
  // start of a row, otherwise only its rightmost column.
  task automatic build_model(input int n_done, input int n_started);
    int k;
    exp_r.delete(); exp_c.delete(); exp_a.delete();
    k = 0;
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) begin
        if (k < n_done) begin exp_r.push_back(r); exp_c.push_back(c); end
        if (k < n_started) begin
          if (c == 0) for (int f = 0; f < K_W; f++) exp_a.push_back(r * IN_W + f);
          else exp_a.push_back(r * IN_W + c + K_W - 1);
        end
        k++;
      end
  endtask

  task automatic prep(input vec_t v);
    ack_mode = v.ack_mode; calc_max = v.calc_max; spurious = v.spurious;
    ack_pend = 0; ack_cnt = 0; calc_left = 0;
    ack_wait_sum = 0; calc_extra_sum = 0;
    outs = 0; loads = 0; dones = 0; last_addr = -1;
    clr_seen = 0; clr_cnt = 0; done_at = -1;
    abort_idx = -1; abort_next = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.col_ack = 1'b0; bus.calc_done = 1'b0; abort = 1'b0;
    if (!rst_ni) begin
      prev_req = 0; prev_ack = 0;
      return;
    end
    if (abort_next) begin abort = 1'b1; abort_next = 0; end
    if (ack_mode == 1) bus.col_ack = (cyc % 3 == 0);
    else if (bus.col_req) begin
      if (!ack_pend) begin
        ack_pend = 1;
        ack_cnt  = (ack_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        ack_wait_sum += ack_cnt;
      end
      if (ack_cnt == 0) begin bus.col_ack = 1'b1; ack_pend = 0; end
      else ack_cnt--;
    end
    if (calc_left > 0) begin
      calc_left--;
      if (calc_left == 0) bus.calc_done = 1'b1;
    end
    if (bus.pe_trigger) begin
      calc_left = int'($urandom_range(1, calc_max));
      calc_extra_sum += calc_left - 1;
      if (abort_idx == outs) begin abort_next = 1; abort_idx = -1; end
    end
    if (spurious) begin
      if (bus.col_req && !bus.calc_done && $urandom_range(0, 3) == 0) bus.calc_done = 1'b1;
      if (!bus.col_req && $urandom_range(0, 2) == 0) bus.col_ack = 1'b1;
    end
    #1;
    chk("load_en", int'(bus.load_en), int'(bus.col_req & bus.col_ack));
    if (prev_req && !prev_ack) begin
      chk("req_hold", int'(bus.col_req), 1);
      chk("addr_hold", int'(bus.col_addr), prev_addr);
    end
    if (bus.load_en) begin
      loads++;
      last_addr = int'(bus.col_addr);
      if (exp_a.size() > 0) chk("col_addr", int'(bus.col_addr), exp_a.pop_front());
      else fail_now("extra_load", int'(bus.col_addr));
    end
    if (bus.out_valid) begin
      outs++;
      if (exp_r.size() > 0) begin
        chk("out_row", int'(bus.out_row), exp_r.pop_front());
        chk("out_col", int'(bus.out_col), exp_c.pop_front());
      end else fail_now("extra_out", int'(bus.out_row) * 256 + int'(bus.out_col));
    end
    if (clr_seen) clr_cnt++;
    else if (bus.pe_clear) begin clr_seen = 1; clr_cnt = 1; end
    if (done) begin
      dones++;
      done_at = clr_cnt;
      chk("busy_at_done", int'(busy), 1);
    end
    prev_req  = bus.col_req;
    prev_ack  = bus.col_ack;
    prev_addr = int'(bus.col_addr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_col_req"}, int'(bus.col_req), 0);
    chk({tag, "_load_en"}, int'(bus.load_en), 0);
    chk({tag, "_pe_clear"}, int'(bus.pe_clear), 0);
    chk({tag, "_pe_trigger"}, int'(bus.pe_trigger), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_col_addr"}, int'(bus.col_addr), 0);
    chk({tag, "_out_row"}, int'(bus.out_row), 0);
    chk({tag, "_out_col"}, int'(bus.out_col), 0);
  endtask

  task automatic run_pass(input vec_t v);
    int n, exp_cyc;
    prep(v);
    build_model(OUT_H * OUT_W, OUT_H * OUT_W);
    start = 1'b1;
    tick();
    if (!v.hold_start) start = 1'b0;
    n = 0;
    while (dones == 0 && n < 20000) begin tick(); n++; end
    start = 1'b0;
    if (dones == 0) fail_now("pass_timeout", n);
    tick();
    chk("busy_after_done", int'(busy), 0);
    tick(); tick();
    chk("done_count", dones, 1);
    chk("out_count", outs, v.exp_outs);
    chk("load_count", loads, v.exp_loads);
    chk("last_addr", last_addr, v.exp_last);
    chk("outs_left", exp_r.size(), 0);
    chk("addrs_left", exp_a.size(), 0);
    if (v.ack_mode != 1) begin
      exp_cyc = 0;
      for (int r = 0; r < OUT_H; r++)
        for (int c = 0; c < OUT_W; c++)
          exp_cyc += 1 + ((c == 0) ? K_W : 1) + 1 + 1 + 1;
      exp_cyc += ack_wait_sum + calc_extra_sum + 1;
      chk("done_cycle", done_at, exp_cyc);
    end
  endtask

  task automatic run_abort();
    int n;
    bit fired;
    prep(tbl[0]);
    build_model(5 * OUT_W + 7, 5 * OUT_W + 8);
    abort_idx = 5 * OUT_W + 7;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; fired = 0;
    while (!fired && n < 5000) begin
      tick(); n++;
      if (abort) fired = 1;
    end
    if (!fired) fail_now("abort_timeout", n);
    tick();
    chk("abort_busy", int'(busy), 0);
    repeat (5) tick();
    chk("abort_done", dones, 0);
    chk("abort_outs", outs, 5 * OUT_W + 7);
    chk("abort_loads", loads, 5 * IN_W + K_W + 7);
    chk("abort_outs_left", exp_r.size(), 0);
    chk("abort_addrs_left", exp_a.size(), 0);
  endtask

  task automatic run_reset_mid();
    int n;
    prep(tbl[0]);
    build_model(OUT_H * OUT_W, OUT_H * OUT_W);
    start = 1'b1;
    tick();
    n = 0;
    while (n < 500) begin
      tick(); n++;
      if (n >= 40 && bus.col_req) break;
    end
    chk("rst_mid_in_fetch", int'(bus.col_req), 1);
    #1 rst_ni = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    tick();
    #1 rst_ni = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    chk("rst_mid_idle_busy", int'(busy), 0);
    chk("rst_mid_no_done", dones, 0);
  endtask

  initial begin
    tbl[0] = '{0, 1, 1'b0, 1'b0, 182, 210, 209};
    tbl[1] = '{1, 1, 1'b0, 1'b0, 182, 210, 209};
    tbl[2] = '{2, 1, 1'b0, 1'b0, 182, 210, 209};
    tbl[3] = '{0, 4, 1'b0, 1'b1, 182, 210, 209};
    tbl[4] = '{2, 3, 1'b1, 1'b0, 182, 210, 209};
    tbl[5] = '{1, 2, 1'b1, 1'b1, 182, 210, 209};
    prep(tbl[0]);
    rst_ni = 1'b1; start = 1'b0; abort = 1'b0;
    bus.col_ack = 1'b0; bus.calc_done = 1'b0;
    #2 rst_ni = 1'b0;
    #2 chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    tick(); tick();
    chk("idle_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) run_pass(tbl[i]);
    run_abort();
    run_pass(tbl[0]);
    run_reset_mid();
    for (int i = 3; i < 6; i++) run_pass(tbl[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_window_seq.md
# conv_window_seq

Sequencer for one convolution layer of the NPU datapath. It walks the output feature map in raster order. For each output position it fetches image columns into the K_H×K_W circular window register, using sliding-window reuse so only one new column is fetched per step. It then clears and fires the PE array, waits for the datapath's completion pulse and reports the finished output coordinate. It sits between the host/image memory port and the conv PE array, replacing per-pixel host trigger writes.

## Interface
Parameters:
- K_H, 3, kernel height (pixels per fetched column)
- K_W, 3, kernel width (columns per full window)
- IN_H, 16, input image height
- IN_W, 15, input image width
- ADDR_W, 16, column address width

Derived constants: OUT_H = IN_H−K_H+1 (14), OUT_W = IN_W−K_W+1 (13).

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start  in  1  begin a layer pass; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when the last output is complete
- col_req  out  1  column fetch request; held until acknowledged
- col_addr  out  ADDR_W  image column address = row·IN_W + fc; stable while col_req is high
- col_ack  in  1  memory has the column on its data bus this cycle
- load_en  out  1  = col_req & col_ack; shifts the column into the window register
- pe_clear  out  1  one-cycle accumulator clear
- pe_trigger  out  1  one-cycle calculation start
- calc_done  in  1  datapath pulse: the result of the current window is ready
- out_valid  out  1  one-cycle pulse; the output at out_row/out_col is complete
- out_row  out  8  output row index, valid with out_valid
- out_col  out  8  output column index, valid with out_valid

## Operation
- Registers:
  - row (0..OUT_H−1)
  - col (0..OUT_W−1)
  - fc: fetch column index (0..IN_W−1)
  - fill: number of columns in the window (0..K_W)
- States: IDLE, CLEAR, FETCH, CALC, WAIT_CALC, ADV, DONE.
- IDLE: when start is high, set row=col=fc=fill=0 and go to CLEAR.
- CLEAR: pe_clear=1, then go to FETCH.
- FETCH:
  - col_req=1.
  - On col_ack: load_en=1, fc++, fill++.
  - When fill reaches K_W on this ack, go to CALC; otherwise stay in FETCH with the next address.
- CALC: pe_trigger=1, then go to WAIT_CALC.
- WAIT_CALC: hold until calc_done, then go to ADV.
- ADV: out_valid=1, with out_row=row and out_col=col. Then:
  - col < OUT_W−1: col++, fill=K_W−1, go to CLEAR. The next FETCH loads exactly one column, fc = col+K_W−1.
  - col = OUT_W−1 and row < OUT_H−1: row++, col=fc=fill=0, go to CLEAR.
  - Otherwise go to DONE.
- DONE: done=1, then go to IDLE.
- abort in any non-IDLE state: go to IDLE next edge. No done or out_valid is issued; counters keep their stale values, which is harmless because start reinitialises them.
- start while busy: ignored.
- col_ack outside FETCH, or calc_done outside WAIT_CALC: ignored. They produce no load_en and no state change.
- col_addr is computed from registered row/fc. The product is truncated to ADDR_W bits.

## Timing
- Reset values:
  - state=IDLE
  - busy, done, col_req, load_en, pe_clear, pe_trigger, out_valid all 0
  - col_addr, out_row, out_col all 0
- All outputs are Moore (decoded from registered state and counters), except load_en, which is combinational on col_ack.
- With zero-wait col_ack and calc_done one cycle after pe_trigger:
  - First output of a row: 7 cycles (CLEAR 1, FETCH K_W, CALC 1, WAIT_CALC 1, ADV 1).
  - Each later output in the row: 5 cycles.
- Full pass at defaults: 14·(7+12·5) = 938 cycles from the CLEAR cycle through the last ADV. done is high in the following cycle, and busy falls one cycle after that.
- Each col_ack wait cycle or calc_done wait cycle adds exactly one cycle.
- Reset asserted mid-pass forces every output to its reset value immediately (asynchronous). The pass restarts only on a new start.

## Test plan
- Reset, then start with col_ack tied high and calc_done = pe_trigger delayed 1 cycle:
  - Exactly 182 out_valid pulses in raster order (0,0)…(13,12).
  - done is high 939 cycles after the CLEAR entry.
  - busy is low afterwards.
- Address sequence for row 0: col_addr = 0,1,2 (first window), then 3,4,…,14, one per output. Row 1 starts with 15,16,17. The last fetch address is 13·15+14 = 209.
- Memory backpressure: col_ack asserted only every 3rd cycle. col_addr and col_req must stay stable between acks. load_en must appear only on ack cycles. The out_valid count is unchanged.
- Spurious inputs: calc_done pulsed during FETCH and col_ack pulsed during WAIT_CALC. Neither may cause a state change, load_en, or an extra out_valid.
- abort asserted during WAIT_CALC of output (5,7): busy is low next cycle, no done is issued, and no out_valid for (5,7). A new start then runs a clean full pass from (0,0).
- Asynchronous rst_ni pulse mid-FETCH: all outputs are 0 immediately. start held high during busy has no effect until IDLE.
